// File: rtl/irq_arbiter_pkg.sv
// Shared constants for the interrupt arbiter: register offsets, id width and FSM state encoding.
package irq_arbiter_pkg;

    localparam int unsigned ID_W = 5;

    localparam logic [31:0] OFF_ENABLE   = 32'h0;
    localparam logic [31:0] OFF_PENDING  = 32'h4;
    localparam logic [31:0] OFF_STATUS   = 32'h8;
    localparam logic [31:0] OFF_COMPLETE = 32'hC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set bit wins, reported as valid + index.
module irq_prio_enc
    import irq_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid_c,
    output logic [ID_W-1:0]    idx_c
);

    // Scan from the top down so the lowest index is the last (winning) assignment.
    always_comb begin
        valid_c = 1'b0;
        idx_c   = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid_c = 1'b1;
                idx_c   = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: edge capture into PENDING, ENABLE masking, priority select and req/ack/complete FSM.
// Define IRQ_SYNC_EN to insert a two-flop synchronizer on irq_src ahead of edge detection.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h5000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               we,
    input  logic [31:0]        waddr,
    input  logic [31:0]        wdata,
    input  logic [31:0]        raddr,
    output logic [31:0]        rdata,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack
);

    localparam logic [31:0] ADDR_ENABLE   = BASE_ADDR + OFF_ENABLE;
    localparam logic [31:0] ADDR_PENDING  = BASE_ADDR + OFF_PENDING;
    localparam logic [31:0] ADDR_STATUS   = BASE_ADDR + OFF_STATUS;
    localparam logic [31:0] ADDR_COMPLETE = BASE_ADDR + OFF_COMPLETE;

    state_t               state;
    logic [NUM_SRC-1:0]   src_s;
    logic [NUM_SRC-1:0]   hist;
    logic [NUM_SRC-1:0]   pending;
    logic [NUM_SRC-1:0]   enable;
    logic [NUM_SRC-1:0]   edge_set;
    logic [NUM_SRC-1:0]   sw_clr;
    logic [NUM_SRC-1:0]   ack_clr;
    logic [NUM_SRC-1:0]   id_mask;
    logic [NUM_SRC-1:0]   sel_req;
    logic                 sel_valid;
    logic [ID_W-1:0]      sel_idx;
    logic                 wr_enable;
    logic                 wr_pending;
    logic                 wr_complete;
    logic                 ack_take;
    logic                 id_enabled;
    logic                 unused_wdata;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1;
    logic [NUM_SRC-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_src;
            sync2 <= sync1;
        end
    end

    assign src_s = sync2;
`else
    assign src_s = irq_src;
`endif

    assign wr_enable    = we && (waddr == ADDR_ENABLE);
    assign wr_pending   = we && (waddr == ADDR_PENDING);
    assign wr_complete  = we && (waddr == ADDR_COMPLETE);
    assign unused_wdata = ^wdata;

    assign id_mask    = NUM_SRC'(1) << irq_id;
    assign id_enabled = (enable & id_mask) != '0;
    assign ack_take   = (state == ST_REQ) && irq_ack;

    // New edges are OR-ed in after the clears, so a simultaneous set always wins.
    assign edge_set = src_s & ~hist;
    assign sw_clr   = wr_pending ? wdata[NUM_SRC-1:0] : '0;
    assign ack_clr  = ack_take ? id_mask : '0;
    assign sel_req  = pending & enable;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req     (sel_req),
        .valid_c (sel_valid),
        .idx_c   (sel_idx)
    );

    // History follows the line even during reset, so a level held through reset is not an edge.
    always_ff @(posedge clk) begin
        hist <= src_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable  <= '0;
            pending <= '0;
            state   <= ST_IDLE;
            irq_req <= 1'b0;
            irq_id  <= '0;
        end else begin
            if (wr_enable) begin
                enable <= wdata[NUM_SRC-1:0];
            end
            pending <= (pending & ~(sw_clr | ack_clr)) | edge_set;

            unique case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state   <= ST_REQ;
                        irq_req <= 1'b1;
                        irq_id  <= sel_idx;
                    end
                end
                ST_REQ: begin
                    // Ack beats withdrawal; irq_id is frozen while the request is up.
                    if (irq_ack) begin
                        state   <= ST_SERVICE;
                        irq_req <= 1'b0;
                    end else if (!id_enabled) begin
                        state   <= ST_IDLE;
                        irq_req <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (wr_complete && (wdata[ID_W-1:0] == irq_id)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (!rst) begin
            case (raddr)
                ADDR_ENABLE:  rdata = 32'(enable);
                ADDR_PENDING: rdata = 32'(pending);
                ADDR_STATUS:  rdata = {22'b0, state, 3'b0, irq_id};
                default:      rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_irq_arbiter;

    localparam logic [31:0] BASE   = 32'h5000_0000;
    localparam logic [31:0] A_EN   = BASE + 32'h0;
    localparam logic [31:0] A_PEND = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_COMP = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        irq_req;
    logic [4:0]  irq_id;
    logic        irq_ack;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic [7:0] m_en   = '0;
    logic [7:0] m_pend = '0;
    logic [7:0] m_hist = '0;
    int         m_state = 0;
    logic       m_req  = 1'b0;
    logic [4:0] m_id   = '0;

    irq_arbiter #(
        .NUM_SRC   (8),
        .BASE_ADDR (BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (raddr),
        .rdata   (rdata),
        .irq_req (irq_req),
        .irq_id  (irq_id),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        logic [7:0] clr;
        logic [7:0] nset;
        int sel;
        if (rst) begin
            m_en = '0; m_pend = '0; m_state = 0; m_req = 1'b0; m_id = '0;
            m_hist = irq_src;
            return;
        end
        nset = irq_src & ~m_hist;
        clr  = (we && waddr == A_PEND) ? wdata[7:0] : 8'h00;
        case (m_state)
            0: begin
                sel = -1;
                for (int i = 7; i >= 0; i--) if (m_pend[i] && m_en[i]) sel = i;
                if (sel >= 0) begin m_state = 1; m_req = 1'b1; m_id = 5'(sel); end
            end
            1: begin
                if (irq_ack) begin m_state = 2; m_req = 1'b0; clr[m_id[2:0]] = 1'b1; end
                else if (!m_en[m_id[2:0]]) begin m_state = 0; m_req = 1'b0; end
            end
            2: if (we && waddr == A_COMP && wdata[4:0] == m_id) m_state = 0;
            default: ;
        endcase
        m_pend = (m_pend & ~clr) | nset;
        if (we && waddr == A_EN) m_en = wdata[7:0];
        m_hist = irq_src;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        raddr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; irq_src = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (irq_req !== 1'b0) $display("FAIL reset_req cyc%0d: got %b want 0", c, irq_req); else n_pass++;
            for (int a = 0; a < 4; a++) begin
                rd(BASE + 32'(a * 4), d);
                n_checks++; if (d !== 32'h0) $display("FAIL reset_rdata off%0d: got %h want 0", a * 4, d); else n_pass++;
            end
        end
        rst = 1'b0;
        tick();
        rd(A_PEND, d);
        n_checks++; if (d !== 32'h0) $display("FAIL reset_pending_after: got %h want 0", d); else n_pass++;
        irq_src = 8'h00;
        tick();
    endtask

    task automatic test_single_source();
        logic [31:0] d;
        wr(A_EN, 32'h04);
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        n_checks++; if (irq_req !== 1'b0) $display("FAIL single_early: got %b want 0", irq_req); else n_pass++;
        tick();
        n_checks++; if (irq_req !== 1'b1) $display("FAIL single_req: got %b want 1", irq_req); else n_pass++;
        n_checks++; if (irq_id !== 5'd2) $display("FAIL single_id: got %0d want 2", irq_id); else n_pass++;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        n_checks++; if (irq_req !== 1'b0) $display("FAIL single_ack_req: got %b want 0", irq_req); else n_pass++;
        rd(A_PEND, d);
        n_checks++; if (d[2] !== 1'b0) $display("FAIL single_pend_clr: got %h want bit2=0", d); else n_pass++;
        rd(A_STAT, d);
        n_checks++; if (d !== 32'h0000_0202) $display("FAIL single_status_svc: got %h want 00000202", d); else n_pass++;
        wr(A_COMP, 32'd2);
        rd(A_STAT, d);
        n_checks++; if (d[9:8] !== 2'd0) $display("FAIL single_complete: got state %0d want 0", d[9:8]); else n_pass++;
    endtask

    task automatic test_priority();
        wr(A_EN, 32'hFF);
        irq_src = 8'h22; tick(); irq_src = 8'h00; tick();
        n_checks++; if (irq_req !== 1'b1 || irq_id !== 5'd1) $display("FAIL prio_first: got req=%b id=%0d want req=1 id=1", irq_req, irq_id); else n_pass++;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        wr(A_COMP, 32'd1);
        n_checks++; if (irq_req !== 1'b0) $display("FAIL prio_gap: got %b want 0", irq_req); else n_pass++;
        tick();
        n_checks++; if (irq_req !== 1'b1 || irq_id !== 5'd5) $display("FAIL prio_second: got req=%b id=%0d want req=1 id=5", irq_req, irq_id); else n_pass++;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        wr(A_COMP, 32'd5);
    endtask

    task automatic test_masking();
        logic [31:0] d;
        wr(A_EN, 32'h00);
        irq_src = 8'h08; tick(); irq_src = 8'h00; tick();
        rd(A_PEND, d);
        n_checks++; if (d !== 32'h08) $display("FAIL mask_pending: got %h want 08", d); else n_pass++;
        n_checks++; if (irq_req !== 1'b0) $display("FAIL mask_noreq: got %b want 0", irq_req); else n_pass++;
        wr(A_EN, 32'h08);
        tick();
        n_checks++; if (irq_req !== 1'b1 || irq_id !== 5'd3) $display("FAIL mask_enable_req: got req=%b id=%0d want req=1 id=3", irq_req, irq_id); else n_pass++;
        wr(A_EN, 32'h00);
        tick();
        n_checks++; if (irq_req !== 1'b0) $display("FAIL mask_withdraw: got %b want 0", irq_req); else n_pass++;
        rd(A_PEND, d);
        n_checks++; if (d !== 32'h08) $display("FAIL mask_pend_kept: got %h want 08", d); else n_pass++;
        rd(A_STAT, d);
        n_checks++; if (d[9:8] !== 2'd0) $display("FAIL mask_state_idle: got %0d want 0", d[9:8]); else n_pass++;
        wr(A_PEND, 32'h08);
        rd(A_PEND, d);
        n_checks++; if (d !== 32'h0) $display("FAIL mask_w1c: got %h want 0", d); else n_pass++;
    endtask

    task automatic test_ack_over_withdraw();
        logic [31:0] d;
        wr(A_EN, 32'hFF);
        irq_src = 8'h40; tick(); irq_src = 8'h00; tick();
        n_checks++; if (irq_req !== 1'b1 || irq_id !== 5'd6) $display("FAIL ackw_req: got req=%b id=%0d want req=1 id=6", irq_req, irq_id); else n_pass++;
        wr(A_EN, 32'h00);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        rd(A_STAT, d);
        n_checks++; if (d !== 32'h0000_0206) $display("FAIL ackw_status: got %h want 00000206", d); else n_pass++;
        wr(A_COMP, 32'd6);
    endtask

    task automatic test_complete_w1c();
        logic [31:0] d;
        wr(A_EN, 32'hFF);
        irq_src = 8'h10; tick(); irq_src = 8'h00; tick();
        n_checks++; if (irq_req !== 1'b1 || irq_id !== 5'd4) $display("FAIL cpl_req: got req=%b id=%0d want req=1 id=4", irq_req, irq_id); else n_pass++;
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        wr(A_COMP, 32'd6);
        rd(A_STAT, d);
        n_checks++; if (d[9:8] !== 2'd2) $display("FAIL cpl_mismatch: got state %0d want 2", d[9:8]); else n_pass++;
        wr(A_COMP, 32'd4);
        rd(A_STAT, d);
        n_checks++; if (d[9:8] !== 2'd0) $display("FAIL cpl_match: got state %0d want 0", d[9:8]); else n_pass++;
        we = 1'b1; waddr = A_PEND; wdata = 32'h01; irq_src = 8'h01;
        tick();
        we = 1'b0; irq_src = 8'h00;
        rd(A_PEND, d);
        n_checks++; if (d !== 32'h01) $display("FAIL w1c_set_wins: got %h want 01", d); else n_pass++;
        tick();
        n_checks++; if (irq_req !== 1'b1 || irq_id !== 5'd0) $display("FAIL w1c_req: got req=%b id=%0d want req=1 id=0", irq_req, irq_id); else n_pass++;
    endtask

    task automatic test_reset_in_req();
        logic [31:0] d;
        rst = 1'b1; tick();
        n_checks++; if (irq_req !== 1'b0) $display("FAIL rstreq_req: got %b want 0", irq_req); else n_pass++;
        rst = 1'b0;
        rd(A_STAT, d);
        n_checks++; if (d !== 32'h0) $display("FAIL rstreq_status: got %h want 0", d); else n_pass++;
        rd(A_EN, d);
        n_checks++; if (d !== 32'h0) $display("FAIL rstreq_enable: got %h want 0", d); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] d;
        int op;
        for (int c = 0; c < 300; c++) begin
            rst     = ($urandom_range(0, 99) == 0);
            irq_src = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            irq_ack = ($urandom_range(0, 2) == 0);
            op = $urandom_range(0, 9);
            we = 1'b0; waddr = 32'h0; wdata = 32'h0;
            if (op == 0) begin we = 1'b1; waddr = A_EN; wdata = $urandom; end
            else if (op == 1) begin we = 1'b1; waddr = A_PEND; wdata = $urandom; end
            else if (op <= 4) begin
                we = 1'b1; waddr = A_COMP;
                wdata = ($urandom_range(0, 1) == 1) ? 32'(m_id) : 32'($urandom_range(0, 7));
            end
            tick();
            n_checks++; if (irq_req !== m_req) $display("FAIL rnd_req c%0d: got %b want %b", c, irq_req, m_req); else n_pass++;
            if (m_req) begin
                n_checks++; if (irq_id !== m_id) $display("FAIL rnd_id c%0d: got %0d want %0d", c, irq_id, m_id); else n_pass++;
            end
            if (!rst) begin
                rd(A_PEND, d);
                n_checks++; if (d !== 32'(m_pend)) $display("FAIL rnd_pend c%0d: got %h want %h", c, d, m_pend); else n_pass++;
                rd(A_STAT, d);
                n_checks++; if (d !== {22'b0, 2'(m_state), 3'b0, m_id}) $display("FAIL rnd_status c%0d: got %h want state=%0d id=%0d", c, d, m_state, m_id); else n_pass++;
                rd(A_EN, d);
                n_checks++; if (d !== 32'(m_en)) $display("FAIL rnd_enable c%0d: got %h want %h", c, d, m_en); else n_pass++;
            end
        end
        we = 1'b0; irq_ack = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_src = 8'h00; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; irq_ack = 1'b0;
        test_reset();
        test_single_source();
        test_priority();
        test_masking();
        test_ack_over_withdraw();
        test_complete_w1c();
        test_reset_in_req();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
